// File: rtl/axis_spi_slave.sv
// SPI responder with AXI-stream TX/RX. Oversamples sen/sclk/mosi in the system clock domain,
// shifts a preloaded response out on miso and delivers the captured mosi word on RX.
module axis_spi_slave #(
    parameter logic        CLK_IDLE     = 1'b0,
    parameter logic        CAPTURE_EDGE = 1'b1,
    parameter logic [31:0] DEFAULT_TX   = 32'h0,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] TX_tdata,
    input  logic        TX_tvalid,
    output logic        TX_tready,
    output logic [31:0] RX_tdata,
    output logic [5:0]  RX_tuser,
    output logic        RX_tvalid,
    input  logic        RX_tready,
    output logic [7:0]  rx_overrun_count,
    output logic [7:0]  tx_underrun_count,
    input  logic        sen,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    typedef enum logic [1:0] {WAIT_DESELECT, IDLE, SHIFT, DONE} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [SYNC_STAGES-1:0] r_senSync;
    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_senPrev;
    logic                   r_sclkPrev;

    logic w_sen;
    logic w_sclk;
    logic w_mosi;
    logic w_primed;
    logic w_senFall;
    logic w_senRise;
    logic w_sclkRise;
    logic w_sclkFall;
    logic w_capture;
    logic w_launch;

    logic [31:0] r_txShift;
    logic [31:0] r_rxShift;
    logic [31:0] r_rxData;
    logic [5:0]  r_bitCount;
    logic [5:0]  r_rxUser;
    logic        r_rxValid;
    logic        r_miso;
    logic        r_misoOe;
    logic [7:0]  r_overrun;
    logic [7:0]  r_underrun;

    // r_flush marks when the synchronizers hold real samples rather than their reset fill,
    // so a frame already running at reset release is not mistaken for a fresh select.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_senSync  <= '1;
            r_sclkSync <= {SYNC_STAGES{CLK_IDLE}};
            r_mosiSync <= '0;
            r_flush    <= '0;
            r_senPrev  <= 1'b1;
            r_sclkPrev <= CLK_IDLE;
        end else begin
            r_senSync  <= {r_senSync[SYNC_STAGES-2:0], sen};
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
            r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_senPrev  <= w_sen;
            r_sclkPrev <= w_sclk;
        end
    end

    assign w_sen      = r_senSync[SYNC_STAGES-1];
    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_primed   = r_flush[SYNC_STAGES-1];
    assign w_senFall  = r_senPrev & ~w_sen;
    assign w_senRise  = ~r_senPrev & w_sen;
    assign w_sclkRise = ~r_sclkPrev & w_sclk;
    assign w_sclkFall = r_sclkPrev & ~w_sclk;
    assign w_capture  = CAPTURE_EDGE ? w_sclkRise : w_sclkFall;
    assign w_launch   = CAPTURE_EDGE ? w_sclkFall : w_sclkRise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_DESELECT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            WAIT_DESELECT: if (w_primed && w_sen) w_stateNext = IDLE;
            IDLE:          if (w_senFall) w_stateNext = SHIFT;
            SHIFT:         if (w_senRise) w_stateNext = DONE;
            DONE:          w_stateNext = IDLE;
            default:       w_stateNext = WAIT_DESELECT;
        endcase
    end

    assign TX_tready = (r_state == IDLE) && w_senFall && TX_tvalid;

    // Launch shifts wait for the first capture so a leading launch edge does not skip bit 31.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_rxData   <= '0;
            r_bitCount <= '0;
            r_rxUser   <= '0;
            r_rxValid  <= 1'b0;
            r_miso     <= 1'b0;
            r_misoOe   <= 1'b0;
            r_overrun  <= '0;
            r_underrun <= '0;
        end else begin
            r_miso <= ((r_state == SHIFT) && !w_senRise) ? r_txShift[31] : 1'b0;
            if (r_rxValid && RX_tready) begin
                r_rxValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_senFall) begin
                        r_txShift  <= TX_tvalid ? TX_tdata : DEFAULT_TX;
                        r_rxShift  <= '0;
                        r_bitCount <= '0;
                        r_misoOe   <= 1'b1;
                        if (!TX_tvalid && (r_underrun != 8'hFF)) begin
                            r_underrun <= r_underrun + 8'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_capture) begin
                        r_rxShift <= {r_rxShift[30:0], w_mosi};
                        if (r_bitCount != 6'd63) begin
                            r_bitCount <= r_bitCount + 6'd1;
                        end
                    end
                    if (w_launch && (r_bitCount != 6'd0)) begin
                        r_txShift <= {r_txShift[30:0], 1'b0};
                    end
                    if (w_senRise) begin
                        r_misoOe <= 1'b0;
                    end
                end
                DONE: begin
                    if (r_bitCount != 6'd0) begin
                        if (!r_rxValid || RX_tready) begin
                            r_rxData  <= r_rxShift;
                            r_rxUser  <= r_bitCount;
                            r_rxValid <= 1'b1;
                        end else if (r_overrun != 8'hFF) begin
                            r_overrun <= r_overrun + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign RX_tdata          = r_rxData;
    assign RX_tuser          = r_rxUser;
    assign RX_tvalid         = r_rxValid;
    assign rx_overrun_count  = r_overrun;
    assign tx_underrun_count = r_underrun;
    assign miso              = r_miso;
    assign miso_oe           = r_misoOe;

endmodule

// File: tb/tb_axis_spi_slave.sv
// Bench for axis_spi_slave: bit-banged mode-0 SPI master with a frame-level reference model
// of the response bits, the RX holding register and the error counters.
module tb_axis_spi_slave;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] TX_tdata;
    logic        TX_tvalid;
    logic        TX_tready;
    logic [31:0] RX_tdata;
    logic [5:0]  RX_tuser;
    logic        RX_tvalid;
    logic        RX_tready;
    logic [7:0]  rx_overrun_count;
    logic [7:0]  tx_underrun_count;
    logic        sen;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;

    int checkCount = 0;
    int failCount  = 0;
    int obsPulses  = 0;
    int expPulses  = 0;
    int expOverrun = 0;
    int expUnderrun = 0;
    logic        expFull = 1'b0;
    logic [31:0] expData = '0;
    logic [5:0]  expUser = '0;
    logic [37:0] obsQ[$];
    logic [37:0] expQ[$];

    axis_spi_slave #(
        .CLK_IDLE(1'b0),
        .CAPTURE_EDGE(1'b1),
        .DEFAULT_TX(32'h0),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .TX_tdata(TX_tdata),
        .TX_tvalid(TX_tvalid),
        .TX_tready(TX_tready),
        .RX_tdata(RX_tdata),
        .RX_tuser(RX_tuser),
        .RX_tvalid(RX_tvalid),
        .RX_tready(RX_tready),
        .rx_overrun_count(rx_overrun_count),
        .tx_underrun_count(tx_underrun_count),
        .sen(sen),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe)
    );

    always #5 clock = ~clock;

    // Handshakes are sampled mid-cycle; inputs only change just after a rising edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (TX_tready) obsPulses++;
            if (RX_tvalid && RX_tready) obsQ.push_back({RX_tdata, RX_tuser});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rstTxReady", 64'(TX_tready), 64'd0);
        checkOutput("rstRxValid", 64'(RX_tvalid), 64'd0);
        checkOutput("rstRxData", 64'(RX_tdata), 64'd0);
        checkOutput("rstRxUser", 64'(RX_tuser), 64'd0);
        checkOutput("rstOverrun", 64'(rx_overrun_count), 64'd0);
        checkOutput("rstUnderrun", 64'(tx_underrun_count), 64'd0);
        checkOutput("rstMiso", 64'(miso), 64'd0);
        checkOutput("rstMisoOe", 64'(miso_oe), 64'd0);
    endtask

    task automatic compareState();
        logic [37:0] o;
        logic [37:0] e;
        checkOutput("beatCount", 64'(obsQ.size()), 64'(expQ.size()));
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            checkOutput("beatData", 64'(o[37:6]), 64'(e[37:6]));
            checkOutput("beatUser", 64'(o[5:0]), 64'(e[5:0]));
        end
        obsQ.delete();
        expQ.delete();
        checkOutput("txReadyPulses", 64'(obsPulses), 64'(expPulses));
        checkOutput("overrun", 64'(rx_overrun_count), 64'(expOverrun));
        checkOutput("underrun", 64'(tx_underrun_count), 64'(expUnderrun));
        checkOutput("rxValid", 64'(RX_tvalid), 64'(expFull));
        if (expFull) begin
            checkOutput("rxHeldData", 64'(RX_tdata), 64'(expData));
            checkOutput("rxHeldUser", 64'(RX_tuser), 64'(expUser));
        end
    endtask

    task automatic drainRx();
        waitCycles(1);
        RX_tready = 1'b1;
        if (expFull) begin
            expQ.push_back({expData, expUser});
            expFull = 1'b0;
        end
        waitCycles(4);
        compareState();
    endtask

    // One master frame of n bits (first sent = bits[n-1]); resetAfter > 0 pulses reset_n after that bit.
    task automatic applyStimulus(input logic [63:0] bits, input int n, input logic txV,
                                 input logic [31:0] txW, input logic rdy, input int resetAfter);
        logic [63:0] rb;
        logic [63:0] expRb;
        logic [63:0] word;
        logic [31:0] txEff;
        bit          wasReset;
        rb = '0;
        wasReset = 0;
        waitCycles(1);
        RX_tready = rdy;
        if (rdy && expFull) begin
            expQ.push_back({expData, expUser});
            expFull = 1'b0;
        end
        TX_tdata  = txW;
        TX_tvalid = txV;
        waitCycles(2);
        sen  = 1'b0;
        mosi = (n > 0) ? bits[n-1] : 1'b0;
        if (txV) expPulses++;
        else if (expUnderrun < 255) expUnderrun++;
        txEff = txV ? txW : 32'h0;
        waitCycles((n == 0) ? 20 : HALF);
        for (int i = 0; i < n; i++) begin
            rb = {rb[62:0], miso};
            if (i == 0 && !wasReset) checkOutput("misoOeActive", 64'(miso_oe), 64'd1);
            sclk = 1'b1;
            waitCycles(HALF);
            sclk = 1'b0;
            mosi = (i + 1 < n) ? bits[n-2-i] : 1'b0;
            if (i + 1 == resetAfter) begin
                reset_n = 1'b0;
                #2;
                checkResetValues();
                waitCycles(2);
                checkResetValues();
                reset_n = 1'b1;
                wasReset = 1;
                expFull = 1'b0;
                expOverrun = 0;
                expUnderrun = 0;
                obsQ.delete();
                expQ.delete();
            end
            waitCycles(HALF);
        end
        sen = 1'b1;
        TX_tvalid = 1'b0;
        waitCycles(12);
        checkOutput("misoOeIdle", 64'(miso_oe), 64'd0);
        checkOutput("misoIdle", 64'(miso), 64'd0);
        if (!wasReset) begin
            expRb = '0;
            for (int i = 0; i < n; i++) expRb = {expRb[62:0], (i < 32) ? txEff[31-i] : 1'b0};
            if (n > 0) checkOutput("readback", rb, expRb);
            if (n > 0) begin
                word = bits & ((64'd1 << n) - 64'd1);
                if (rdy) begin
                    expQ.push_back({word[31:0], 6'((n > 63) ? 63 : n)});
                end else if (!expFull) begin
                    expFull = 1'b1;
                    expData = word[31:0];
                    expUser = 6'((n > 63) ? 63 : n);
                end else if (expOverrun < 255) begin
                    expOverrun++;
                end
            end
        end
        compareState();
    endtask

    initial begin
        reset_n   = 1'b0;
        sen       = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        TX_tdata  = '0;
        TX_tvalid = 1'b0;
        RX_tready = 1'b0;
        waitCycles(3);
        checkResetValues();
        reset_n = 1'b1;
        waitCycles(6);

        applyStimulus(64'hA5A50F0F, 32, 1'b1, 32'h12345678, 1'b1, -1);
        applyStimulus(64'h3C, 8, 1'b1, 32'hC3000000, 1'b1, -1);
        applyStimulus(64'h5A5A, 16, 1'b0, 32'hFFFFFFFF, 1'b1, -1);
        applyStimulus(64'h1111, 16, 1'b1, 32'h0BADF00D, 1'b0, -1);
        applyStimulus(64'h2222, 16, 1'b1, 32'h600DCAFE, 1'b0, -1);
        drainRx();
        applyStimulus(64'h0, 0, 1'b1, 32'hCAFEF00D, 1'b1, -1);
        applyStimulus(64'h13579BDF, 32, 1'b1, 32'h2468ACE0, 1'b1, 10);
        applyStimulus(64'hDEADBEEF, 32, 1'b1, 32'h89ABCDEF, 1'b1, -1);

        for (int k = 0; k < 28; k++) begin
            applyStimulus({$urandom, $urandom}, int'($urandom_range(0, 40)),
                          ($urandom_range(0, 3) != 0), $urandom,
                          ($urandom_range(0, 2) != 0), -1);
        end
        drainRx();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
